loba_split_pipe: RTL

- Pipelined operand-split front end for the 16-bit LOBA3 product datapath.
- Takes an operand pair (A, B) over a valid/ready handshake.
- For each operand, produces the high and low 4-bit leading-one segments and their bit positions in registers (Ah/k1a/Al/k2a, Bh/k1b/Bl/k2b).
- Sits directly upstream of the four-partial-product multiply/shift stage, which consumes these fields unchanged.

---
 rtl/loba_split_pipe_if.sv | 34 +++
 rtl/loba_split_pipe.sv | 132 +++++++++++++
 2 files changed

// File: rtl/loba_split_pipe_if.sv
// Operand-pair in / split-fields out bundle for the LOBA3 split front end.
// The slave view belongs to the pipe; the master view belongs to whoever feeds and drains it.
interface loba_split_pipe_if #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int KW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [SEG-1:0]   ah;
  logic [SEG-1:0]   al;
  logic [KW-1:0]    k1a;
  logic [KW-1:0]    k2a;
  logic [SEG-1:0]   bh;
  logic [SEG-1:0]   bl;
  logic [KW-1:0]    k1b;
  logic [KW-1:0]    k2b;
  logic             a_zero;
  logic             b_zero;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, ah, al, k1a, k2a, bh, bl, k1b, k2b, a_zero, b_zero
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, ah, al, k1a, k2a, bh, bl, k1b, k2b, a_zero, b_zero
  );
endinterface

// File: rtl/loba_split_pipe.sv
// Splits A and B into high/low 4-bit leading-one segments plus positions; two register stages, no bubbles.
// Valid/ready on both sides: a stage refills in the cycle it drains, in_ready falls only when both stages hold data.
module loba_split_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int KW    = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst_n,
  loba_split_pipe_if.slave bus
);
  typedef struct packed {
    logic [SEG-1:0] seg;
    logic [KW-1:0]  k;
  } seg_t;

  typedef struct packed {
    seg_t             hi;
    logic [WIDTH-1:0] res;
    logic             zero;
  } s1_t;

  typedef struct packed {
    seg_t hi;
    seg_t lo;
    logic zero;
  } s2_t;

  localparam logic [KW-1:0]    KMIN     = KW'(SEG - 1);
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'((1 << SEG) - 1);

  // Leading-one index clamped to SEG-1, so the segment window never runs off bit 0.
  function automatic logic [KW-1:0] lead_k(input logic [WIDTH-1:0] x);
    logic [KW-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) p = KW'(i);
    end
    if (p < KMIN) p = KMIN;
    return p;
  endfunction

  function automatic logic [SEG-1:0] seg_at(input logic [WIDTH-1:0] x, input logic [KW-1:0] k);
    return SEG'(x >> (k - KMIN));
  endfunction

  function automatic logic [WIDTH-1:0] clear_at(input logic [WIDTH-1:0] x, input logic [KW-1:0] k);
    return x & ~(SEG_MASK << (k - KMIN));
  endfunction

  function automatic s1_t split_hi(input logic [WIDTH-1:0] x);
    s1_t r;
    r.hi.k   = lead_k(x);
    r.hi.seg = seg_at(x, r.hi.k);
    r.res    = clear_at(x, r.hi.k);
    r.zero   = (x == '0);
    return r;
  endfunction

  function automatic s2_t split_lo(input s1_t s);
    s2_t r;
    r.hi     = s.hi;
    r.lo.k   = lead_k(s.res);
    r.lo.seg = seg_at(s.res, r.lo.k);
    r.zero   = s.zero;
    return r;
  endfunction

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1a_q, s1a_d, s1b_q, s1b_d;
  s2_t  s2a_q, s2a_d, s2b_q, s2b_d;
  logic s2_adv, s1_adv, in_fire;

  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = s1_valid_q && s2_adv;
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1a_d      = s1a_q;
    s1b_d      = s1b_q;
    s2_valid_d = s2_valid_q;
    s2a_d      = s2a_q;
    s2b_d      = s2b_q;

    if (s1_adv) s1_valid_d = 1'b0;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1a_d      = split_hi(bus.a);
      s1b_d      = split_hi(bus.b);
    end

    // Stage 2 data only moves when a real pair arrives, so outputs stay put while idle.
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s1_adv) begin
      s2a_d = split_lo(s1a_q);
      s2b_d = split_lo(s1b_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1a_q      <= '0;
      s1b_q      <= '0;
      s2a_q      <= '0;
      s2b_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1a_q      <= s1a_d;
      s1b_q      <= s1b_d;
      s2a_q      <= s2a_d;
      s2b_q      <= s2b_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.ah        = s2a_q.hi.seg;
  assign bus.k1a       = s2a_q.hi.k;
  assign bus.al        = s2a_q.lo.seg;
  assign bus.k2a       = s2a_q.lo.k;
  assign bus.a_zero    = s2a_q.zero;
  assign bus.bh        = s2b_q.hi.seg;
  assign bus.k1b       = s2b_q.hi.k;
  assign bus.bl        = s2b_q.lo.seg;
  assign bus.k2b       = s2b_q.lo.k;
  assign bus.b_zero    = s2b_q.zero;
endmodule
